// File: rtl/lagarto0_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lagarto0_pkg                                                          |
// | Shared lagarto0 core sizes and the instruction-queue entry type.      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package lagarto0_pkg;

  localparam int ADDR_SIZE        = 64;
  localparam int ISA_SIZE         = 32;
  localparam int ICACHE_LINE_SIZE = 64;
  localparam int IQUEUE_DEPTH     = 4;
  localparam int IQUEUE_ADDR_SIZE = $clog2(IQUEUE_DEPTH);
  localparam int IQUEUE_CNT_SIZE  = IQUEUE_ADDR_SIZE + 1;

  typedef struct packed {
    logic [ISA_SIZE-1:0]  instr;
    logic [ADDR_SIZE-1:0] pc;
  } iq_entry_t;

endpackage
`default_nettype wire

// File: rtl/lagarto0_iqueue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lagarto0_iqueue                                                       |
// | Unpacks 2-instruction fetch packets into a circular queue and issues  |
// | one instruction per cycle to decode.                                  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module lagarto0_iqueue
  import lagarto0_pkg::*;
#(
  parameter int DEPTH   = IQUEUE_DEPTH,
  parameter int XLEN_PC = ADDR_SIZE,
  parameter int INSTR_W = ISA_SIZE,
  parameter int LINE_W  = ICACHE_LINE_SIZE
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               flush_i,
  input  logic               fetch_valid_i,
  output logic               fetch_ready_o,
  input  logic [XLEN_PC-1:0] fetch_pc_i,
  input  logic [LINE_W-1:0]  fetch_data_i,
  output logic               dec_valid_o,
  input  logic               dec_ready_i,
  output logic [INSTR_W-1:0] dec_instr_o,
  output logic [XLEN_PC-1:0] dec_pc_o
);

  localparam int c_addr_w = $clog2(DEPTH);
  localparam int c_cnt_w  = c_addr_w + 1;
  // Highest occupancy at which a full two-instruction packet still fits.
  localparam logic [c_cnt_w-1:0] c_ready_max = c_cnt_w'(DEPTH - 2);

  logic [INSTR_W-1:0]  r_instr [DEPTH];
  logic [XLEN_PC-1:0]  r_pc    [DEPTH];
  logic [c_addr_w-1:0] r_rd_ptr;
  logic [c_addr_w-1:0] r_wr_ptr;
  logic [c_cnt_w-1:0]  r_count;

  logic                w_push;
  logic                w_pop;
  logic                w_two;
  logic [c_addr_w-1:0] w_wr_ptr_p1;
  logic [c_cnt_w-1:0]  w_push_cnt;

  assign fetch_ready_o = rstn_i & (r_count <= c_ready_max);
  assign dec_valid_o   = rstn_i & (r_count != '0);

  // A packet whose PC sits in the upper half of the 8-byte line carries one useful slot.
  assign w_two       = ~fetch_pc_i[2];
  assign w_push      = fetch_valid_i & fetch_ready_o & ~flush_i;
  assign w_pop       = dec_valid_o & dec_ready_i & ~flush_i;
  assign w_wr_ptr_p1 = r_wr_ptr + c_addr_w'(1);
  assign w_push_cnt  = !w_push ? '0 : (w_two ? c_cnt_w'(2) : c_cnt_w'(1));

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + w_push_cnt[c_addr_w-1:0];
      r_rd_ptr <= r_rd_ptr + c_addr_w'(w_pop);
      r_count  <= r_count + w_push_cnt - c_cnt_w'(w_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      if (w_two) begin
        r_instr[r_wr_ptr]    <= fetch_data_i[INSTR_W-1:0];
        r_pc[r_wr_ptr]       <= fetch_pc_i;
        r_instr[w_wr_ptr_p1] <= fetch_data_i[LINE_W-1:INSTR_W];
        r_pc[w_wr_ptr_p1]    <= fetch_pc_i + XLEN_PC'(4);
      end else begin
        r_instr[r_wr_ptr]    <= fetch_data_i[LINE_W-1:INSTR_W];
        r_pc[r_wr_ptr]       <= fetch_pc_i;
      end
    end
  end

  assign dec_instr_o = dec_valid_o ? r_instr[r_rd_ptr] : '0;
  assign dec_pc_o    = dec_valid_o ? r_pc[r_rd_ptr]    : '0;

  a_no_overfill: assert property (@(posedge clk_i) disable iff (!rstn_i)
    w_push |-> (r_count <= c_ready_max));
  a_no_underflow: assert property (@(posedge clk_i) disable iff (!rstn_i)
    w_pop |-> (r_count != '0));
  a_pc_aligned: assert property (@(posedge clk_i) disable iff (!rstn_i)
    fetch_valid_i |-> (fetch_pc_i[1:0] == 2'b00));

endmodule
`default_nettype wire

// File: tb/tb_lagarto0_iqueue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_lagarto0_iqueue                                                    |
// | Directed steps plus a valid/ready soak against a reference queue.     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_lagarto0_iqueue;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        flush_i;
  logic        fetch_valid_i;
  logic        fetch_ready_o;
  logic [63:0] fetch_pc_i;
  logic [63:0] fetch_data_i;
  logic        dec_valid_o;
  logic        dec_ready_i;
  logic [31:0] dec_instr_o;
  logic [63:0] dec_pc_o;

  int errors = 0;
  int checks = 0;

  lagarto0_iqueue dut (
    .clk_i         (clk_i),
    .rstn_i        (rstn_i),
    .flush_i       (flush_i),
    .fetch_valid_i (fetch_valid_i),
    .fetch_ready_o (fetch_ready_o),
    .fetch_pc_i    (fetch_pc_i),
    .fetch_data_i  (fetch_data_i),
    .dec_valid_o   (dec_valid_o),
    .dec_ready_i   (dec_ready_i),
    .dec_instr_o   (dec_instr_o),
    .dec_pc_o      (dec_pc_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_head(input string tag, input logic [31:0] instr, input logic [63:0] pc);
    check({tag, "_valid"}, {63'd0, dec_valid_o}, 64'd1);
    check({tag, "_instr"}, {32'd0, dec_instr_o}, {32'd0, instr});
    check({tag, "_pc"}, dec_pc_o, pc);
  endtask

  task automatic check_empty(input string tag);
    check({tag, "_valid"}, {63'd0, dec_valid_o}, 64'd0);
    check({tag, "_instr"}, {32'd0, dec_instr_o}, 64'd0);
    check({tag, "_pc"}, dec_pc_o, 64'd0);
  endtask

  logic [95:0] model_q[$];

  initial begin
    rstn_i        = 1'b0;
    flush_i       = 1'b0;
    fetch_valid_i = 1'b0;
    fetch_pc_i    = 64'd0;
    fetch_data_i  = 64'd0;
    dec_ready_i   = 1'b0;

    // Reset held for three edges
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_fetch_ready", {63'd0, fetch_ready_o}, 64'd0);
      check_empty("rst");
    end
    rstn_i = 1'b1;
    #1;
    check("post_rst_fetch_ready", {63'd0, fetch_ready_o}, 64'd1);
    check_empty("post_rst");

    // Aligned packet issues lower half first
    fetch_valid_i = 1'b1;
    fetch_pc_i    = 64'h1000;
    fetch_data_i  = 64'h00500093_00100013;
    dec_ready_i   = 1'b1;
    tick();
    fetch_valid_i = 1'b0;
    check_head("aligned_0", 32'h00100013, 64'h1000);
    tick();
    check_head("aligned_1", 32'h00500093, 64'h1004);
    tick();
    check_empty("aligned_drained");

    // Upper-half packet carries a single instruction
    fetch_valid_i = 1'b1;
    fetch_pc_i    = 64'h2004;
    fetch_data_i  = 64'hDEADBEEF_11111111;
    dec_ready_i   = 1'b0;
    tick();
    fetch_valid_i = 1'b0;
    check_head("single", 32'hDEADBEEF, 64'h2004);
    check("single_fetch_ready", {63'd0, fetch_ready_o}, 64'd1);
    dec_ready_i = 1'b1;
    tick();
    check_empty("single_drained");

    // Fill to DEPTH, then drain while a held packet waits for room
    dec_ready_i   = 1'b0;
    fetch_valid_i = 1'b1;
    fetch_pc_i    = 64'h0;
    fetch_data_i  = 64'h11110004_11110000;
    tick();
    check("fill_half_ready", {63'd0, fetch_ready_o}, 64'd1);
    fetch_pc_i   = 64'h8;
    fetch_data_i = 64'h1111000C_11110008;
    tick();
    check("full_ready", {63'd0, fetch_ready_o}, 64'd0);
    check_head("full_head", 32'h11110000, 64'h0);
    fetch_pc_i   = 64'h10;
    fetch_data_i = 64'h11110014_11110010;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_ready", {63'd0, fetch_ready_o}, 64'd0);
      check("hold_pc", dec_pc_o, 64'h0);
    end
    dec_ready_i = 1'b1;
    tick();
    check_head("drain_1", 32'h11110004, 64'h4);
    check("drain_1_ready", {63'd0, fetch_ready_o}, 64'd0);
    tick();
    check_head("drain_2", 32'h11110008, 64'h8);
    check("drain_2_ready", {63'd0, fetch_ready_o}, 64'd1);
    tick();
    fetch_valid_i = 1'b0;
    check_head("drain_3", 32'h1111000C, 64'hC);
    tick();
    check_head("drain_4", 32'h11110010, 64'h10);
    tick();
    check_head("drain_5", 32'h11110014, 64'h14);
    tick();
    check_empty("drain_done");

    // Three entries: single-slot packet still refused, then flush with push and pop
    dec_ready_i   = 1'b0;
    fetch_valid_i = 1'b1;
    fetch_pc_i    = 64'h100;
    fetch_data_i  = 64'h33330104_33330100;
    tick();
    fetch_pc_i   = 64'h10C;
    fetch_data_i = 64'h3333010C_00000000;
    tick();
    check("three_ready", {63'd0, fetch_ready_o}, 64'd0);
    fetch_pc_i   = 64'h204;
    fetch_data_i = 64'h44440204_00000000;
    tick();
    check("three_hold_ready", {63'd0, fetch_ready_o}, 64'd0);
    check_head("three_head", 32'h33330100, 64'h100);
    flush_i       = 1'b1;
    dec_ready_i   = 1'b1;
    fetch_pc_i    = 64'h200;
    fetch_data_i  = 64'h55550204_55550200;
    tick();
    flush_i       = 1'b0;
    fetch_valid_i = 1'b0;
    check_empty("flush3");
    check("flush3_ready", {63'd0, fetch_ready_o}, 64'd1);
    tick();
    check_empty("flush3_after");

    // Flush must also drop a push that would otherwise be accepted
    dec_ready_i   = 1'b0;
    fetch_valid_i = 1'b1;
    fetch_pc_i    = 64'h304;
    fetch_data_i  = 64'h66660304_00000000;
    tick();
    flush_i      = 1'b1;
    dec_ready_i  = 1'b1;
    fetch_pc_i   = 64'h400;
    fetch_data_i = 64'h77770404_77770400;
    tick();
    flush_i       = 1'b0;
    fetch_valid_i = 1'b0;
    check_empty("flush1");
    tick();
    check_empty("flush1_after");

    // Count 1 with simultaneous push and pop
    dec_ready_i   = 1'b0;
    fetch_valid_i = 1'b1;
    fetch_pc_i    = 64'h504;
    fetch_data_i  = 64'h22220504_00000000;
    tick();
    check_head("pp_pre", 32'h22220504, 64'h504);
    fetch_pc_i   = 64'h508;
    fetch_data_i = 64'h2222050C_22220508;
    dec_ready_i  = 1'b1;
    tick();
    fetch_valid_i = 1'b0;
    check_head("pp_0", 32'h22220508, 64'h508);
    tick();
    check_head("pp_1", 32'h2222050C, 64'h50C);
    tick();
    check_empty("pp_done");

    // Soak against a reference queue; stops at the first mismatch
    model_q.delete();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      int          err_before;
      bit          m_ready;
      bit          m_valid;
      logic [63:0] pc;
      logic [63:0] data;
      err_before = errors;
      m_ready = (4 - model_q.size()) >= 2;
      m_valid = model_q.size() != 0;
      check("soak_ready", {63'd0, fetch_ready_o}, {63'd0, m_ready});
      check("soak_valid", {63'd0, dec_valid_o}, {63'd0, m_valid});
      if (m_valid) begin
        check("soak_instr", {32'd0, dec_instr_o}, {32'd0, model_q[0][95:64]});
        check("soak_pc", dec_pc_o, model_q[0][63:0]);
      end
      if (errors != err_before) break;

      pc            = {$urandom(), $urandom()};
      pc[1:0]       = 2'b00;
      data          = {$urandom(), $urandom()};
      fetch_pc_i    = pc;
      fetch_data_i  = data;
      fetch_valid_i = ($urandom_range(0, 3) != 0);
      dec_ready_i   = ($urandom_range(0, 2) != 0);
      flush_i       = ($urandom_range(0, 63) == 0);

      if (flush_i) begin
        model_q.delete();
      end else begin
        if (m_valid && dec_ready_i) void'(model_q.pop_front());
        if (fetch_valid_i && m_ready) begin
          if (!pc[2]) begin
            model_q.push_back({data[31:0], pc});
            model_q.push_back({data[63:32], pc + 64'd4});
          end else begin
            model_q.push_back({data[63:32], pc});
          end
        end
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
